lock_code_checker: RTL and testbench

LOCK_CODE_CHECKER -- requirements
Module: lock_code_checker

---
 rtl/lock_code_checker_pkg.sv | 34 +++
 rtl/lock_code_checker_timer.sv | 35 +++
 rtl/lock_code_checker.sv | 207 ++++++++++++++++++++
 tb/tb_lock_code_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_code_checker_pkg.sv
// Shared lock constants: FSM state encoding, digit width and the
// helpers that turn raw button pulses into a digit.
//   DIGIT_WIDTH  : bits per code digit (four buttons -> 2 bits)
//   NUM_BUTTONS  : width of the press-pulse bus from the button monitor
//   lockState_t  : LOCKED / UNLOCKED / CONFIRM / LOCKOUT
package lock_code_checker_pkg;

  localparam int DIGIT_WIDTH = 2;
  localparam int NUM_BUTTONS = 4;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    CONFIRM  = 2'd2,
    LOCKOUT  = 2'd3
  } lockState_t;

  // A press only counts when exactly one button pulses; clearing the
  // lowest set bit leaves zero only for a one-hot value.
  function automatic logic isValidPress(input logic [NUM_BUTTONS-1:0] presses);
    return (presses != '0) && ((presses & (presses - NUM_BUTTONS'(1))) == '0);
  endfunction

  // Index of the pulsing button, meaningful only for a valid press.
  function automatic logic [DIGIT_WIDTH-1:0] pressToDigit(input logic [NUM_BUTTONS-1:0] presses);
    logic [DIGIT_WIDTH-1:0] digit;
    digit = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (presses[i]) digit = DIGIT_WIDTH'(i);
    end
    return digit;
  endfunction

endpackage

// File: rtl/lock_code_checker_timer.sv
// cycle_timer: loadable down-counter used for both the entry timeout and
// the lockout duration.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset, clears the count
//   load      : reload the counter with loadValue this cycle
//   loadValue : number of cycles until expiry
//   expired   : high during the last counted cycle, so an owner acting on
//               it at the next edge acts exactly loadValue cycles after
//               the loading edge
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Counting stops at zero so an idle timer never expires again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/lock_code_checker.sv
// lock_code_checker: digit-code lock with code change (enter + confirm),
// failed-attempt lockout and partial-entry timeout.
//   clock         : rising-edge clock
//   reset         : asynchronous active-low reset
//   buttonPresses : one-cycle press pulses, bit i is digit i
//   locked        : registered, high while the lock is closed
//   error         : one-cycle pulse on a failed entry or failed confirm
//   lockout       : high while further presses are being refused
//   digitCount    : digits captured so far in the current entry
module lock_code_checker
  import lock_code_checker_pkg::*;
#(
  parameter int unsigned CODE_LENGTH = 4,
  parameter logic [DIGIT_WIDTH*CODE_LENGTH-1:0] DEFAULT_CODE = 8'b11_10_01_00,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonPresses,
  output logic                   locked,
  output logic                   error,
  output logic                   lockout,
  output logic [2:0]             digitCount
);

  localparam int CODE_WIDTH    = DIGIT_WIDTH * CODE_LENGTH;
  localparam int ATTEMPT_WIDTH = $clog2(MAX_ATTEMPTS + 1);
  localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LOCKOUT_WIDTH = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0]               LAST_POSITION = 3'(CODE_LENGTH - 1);
  localparam logic [ATTEMPT_WIDTH-1:0] ATTEMPT_LIMIT = ATTEMPT_WIDTH'(MAX_ATTEMPTS);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LOAD  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [LOCKOUT_WIDTH-1:0] LOCKOUT_LOAD  = LOCKOUT_WIDTH'(LOCKOUT_CYCLES);

  lockState_t state, stateNext;
  logic [CODE_WIDTH-1:0]    storedCode, storedCodeNext;
  logic [CODE_WIDTH-1:0]    candidate, candidateNext;
  logic [CODE_WIDTH-1:0]    entry, entryNext;
  logic [CODE_WIDTH-1:0]    fullEntry, fullCandidate;
  logic [ATTEMPT_WIDTH-1:0] attempts, attemptsNext, attemptsInc;
  logic [2:0]               digitCountNext;
  logic                     errorNext, lockedNext, lockoutNext;
  logic                     validPress, lastDigit, timedOut;
  logic [DIGIT_WIDTH-1:0]   pressDigit;
  logic                     timeoutLoad, timeoutExpired;
  logic                     lockoutLoad, lockoutExpired;

  function automatic logic [CODE_WIDTH-1:0] insertDigit(
    input logic [CODE_WIDTH-1:0]  code,
    input logic [2:0]             position,
    input logic [DIGIT_WIDTH-1:0] digit
  );
    logic [CODE_WIDTH-1:0] result;
    result = code;
    result[int'(position)*DIGIT_WIDTH +: DIGIT_WIDTH] = digit;
    return result;
  endfunction

  cycle_timer #(.WIDTH(TIMEOUT_WIDTH)) timeoutTimer (
    .clock     (clock),
    .reset     (reset),
    .load      (timeoutLoad),
    .loadValue (TIMEOUT_LOAD),
    .expired   (timeoutExpired)
  );

  cycle_timer #(.WIDTH(LOCKOUT_WIDTH)) lockoutTimer (
    .clock     (clock),
    .reset     (reset),
    .load      (lockoutLoad),
    .loadValue (LOCKOUT_LOAD),
    .expired   (lockoutExpired)
  );

  assign validPress    = isValidPress(buttonPresses);
  assign pressDigit    = pressToDigit(buttonPresses);
  assign lastDigit     = (digitCount == LAST_POSITION);
  assign fullEntry     = insertDigit(entry, digitCount, pressDigit);
  assign fullCandidate = insertDigit(candidate, digitCount, pressDigit);
  assign attemptsInc   = attempts + ATTEMPT_WIDTH'(1);
  // The timeout timer keeps running after an entry completes, so its
  // expiry only matters while a partial entry is pending.
  assign timedOut      = timeoutExpired && (digitCount != 3'd0);

  // Next-state logic. Every accepted press reloads the timeout timer,
  // which is why a press landing on the expiry cycle wins. The error
  // pulse is suppressed if error is already high so it can never stretch.
  always_comb begin
    stateNext      = state;
    storedCodeNext = storedCode;
    candidateNext  = candidate;
    entryNext      = entry;
    attemptsNext   = attempts;
    digitCountNext = digitCount;
    errorNext      = 1'b0;
    timeoutLoad    = 1'b0;
    lockoutLoad    = 1'b0;

    case (state)
      LOCKED: begin
        if (validPress) begin
          timeoutLoad = 1'b1;
          if (lastDigit) begin
            digitCountNext = 3'd0;
            if (fullEntry == storedCode) begin
              stateNext    = UNLOCKED;
              attemptsNext = '0;
            end else begin
              errorNext    = !error;
              attemptsNext = attemptsInc;
              if (attemptsInc >= ATTEMPT_LIMIT) begin
                stateNext   = LOCKOUT;
                lockoutLoad = 1'b1;
              end
            end
          end else begin
            entryNext      = fullEntry;
            digitCountNext = digitCount + 3'd1;
          end
        end else if (timedOut) begin
          digitCountNext = 3'd0;
        end
      end

      UNLOCKED: begin
        if (validPress) begin
          timeoutLoad   = 1'b1;
          candidateNext = fullCandidate;
          if (lastDigit) begin
            stateNext      = CONFIRM;
            digitCountNext = 3'd0;
          end else begin
            digitCountNext = digitCount + 3'd1;
          end
        end else if (timedOut) begin
          digitCountNext = 3'd0;
        end
      end

      CONFIRM: begin
        if (validPress) begin
          timeoutLoad = 1'b1;
          if (lastDigit) begin
            digitCountNext = 3'd0;
            if (fullEntry == candidate) begin
              storedCodeNext = candidate;
              stateNext      = LOCKED;
            end else begin
              errorNext = !error;
              stateNext = UNLOCKED;
            end
          end else begin
            entryNext      = fullEntry;
            digitCountNext = digitCount + 3'd1;
          end
        end else if (timedOut) begin
          digitCountNext = 3'd0;
          stateNext      = UNLOCKED;
        end
      end

      LOCKOUT: begin
        if (lockoutExpired) begin
          stateNext    = LOCKED;
          attemptsNext = '0;
        end
      end

      default: begin
        stateNext = LOCKED;
      end
    endcase

    lockedNext  = (stateNext == LOCKED) || (stateNext == LOCKOUT);
    lockoutNext = (stateNext == LOCKOUT);
  end

  // State and output registers; locked/lockout are registered from the
  // next state so they follow the deciding press by exactly one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= LOCKED;
      storedCode <= DEFAULT_CODE;
      candidate  <= '0;
      entry      <= '0;
      attempts   <= '0;
      digitCount <= 3'd0;
      error      <= 1'b0;
      locked     <= 1'b1;
      lockout    <= 1'b0;
    end else begin
      state      <= stateNext;
      storedCode <= storedCodeNext;
      candidate  <= candidateNext;
      entry      <= entryNext;
      attempts   <= attemptsNext;
      digitCount <= digitCountNext;
      error      <= errorNext;
      locked     <= lockedNext;
      lockout    <= lockoutNext;
    end
  end

endmodule

// File: tb/tb_lock_code_checker.sv
// Testbench for lock_code_checker with short timeout (20) and lockout (50)
// so the timing corners can be walked cycle by cycle.
module tb_lock_code_checker;
  import lock_code_checker_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttonPresses = 4'b0000;
  logic       locked, error, lockout;
  logic [2:0] digitCount;

  lock_code_checker #(
    .CODE_LENGTH    (4),
    .DEFAULT_CODE   (8'b11_10_01_00),
    .MAX_ATTEMPTS   (3),
    .TIMEOUT_CYCLES (20),
    .LOCKOUT_CYCLES (50)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .buttonPresses (buttonPresses),
    .locked        (locked),
    .error         (error),
    .lockout       (lockout),
    .digitCount    (digitCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] press;
    logic       expLocked;
    logic       expError;
    logic       expLockout;
    logic [2:0] expCount;
  } vector_t;

  typedef struct packed {
    logic       expLocked;
    logic       expError;
    logic       expLockout;
    logic [2:0] expCount;
  } expect_t;

  expect_t expQ[$];
  string   tagQ[$];
  vector_t vectors[$];
  int      testsRun = 0;
  int      testsFailed = 0;
  int      stepCount = 0;
  string   phase = "init";

  // Gives up loudly if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] digitPress(input logic [1:0] d);
    logic [3:0] p;
    p = 4'b0001;
    return p << d;
  endfunction

  task automatic compareField(input string what, input string tag,
                              input logic [7:0] actual, input logic [7:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", tag, what, actual, required);
    end
  endtask

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic checkOutput();
    expect_t e;
    string   tag;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: queue empty, got 0 entries, expected 1");
      return;
    end
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    compareField("locked",     tag, 8'(locked),     8'(e.expLocked));
    compareField("error",      tag, 8'(error),      8'(e.expError));
    compareField("lockout",    tag, 8'(lockout),    8'(e.expLockout));
    compareField("digitCount", tag, 8'(digitCount), 8'(e.expCount));
  endtask

  // Drives one cycle of input, records what must appear after the edge,
  // then samples 1 time unit after that edge.
  task automatic applyStimulus(input logic [3:0] press, input logic eLocked,
                               input logic eError, input logic eLockout,
                               input logic [2:0] eCount);
    stepCount++;
    buttonPresses = press;
    expQ.push_back({eLocked, eError, eLockout, eCount});
    tagQ.push_back($sformatf("%s step %0d", phase, stepCount));
    @(posedge clock);
    #1;
    buttonPresses = 4'b0000;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic eLocked, input logic eLockout,
                      input logic [2:0] eCount);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, eLocked, 1'b0, eLockout, eCount);
  endtask

  // Four presses, digit 0 in the LSBs; intermediate presses keep
  // holdLocked, the final press must produce the given outcome.
  task automatic enterCode(input logic [7:0] code, input logic holdLocked,
                           input logic endLocked, input logic endError,
                           input logic endLockout);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(digitPress(code[2*i +: 2]), holdLocked, 1'b0, 1'b0, 3'(i + 1));
      else       applyStimulus(digitPress(code[2*i +: 2]), endLocked, endError, endLockout, 3'd0);
    end
  endtask

  // Asserts reset away from the clock edge, checks the outputs cleared
  // without waiting for a clock, then releases after one edge.
  task automatic pulseReset();
    reset = 1'b0;
    expQ.push_back({1'b1, 1'b0, 1'b0, 3'd0});
    tagQ.push_back($sformatf("%s async reset", phase));
    #1;
    checkOutput();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic reachLockout();
    for (int k = 0; k < 2; k++) begin
      enterCode(8'b11_11_11_11, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(1, 1'b1, 1'b0, 3'd0);
    end
    enterCode(8'b11_11_11_11, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    vector_t v;

    // Default-code unlock with ignored zero and multi-bit cycles mixed in.
    vectors.push_back({4'b0001, 1'b1, 1'b0, 1'b0, 3'd1});
    vectors.push_back({4'b0000, 1'b1, 1'b0, 1'b0, 3'd1});
    vectors.push_back({4'b0011, 1'b1, 1'b0, 1'b0, 3'd1});
    vectors.push_back({4'b0010, 1'b1, 1'b0, 1'b0, 3'd2});
    vectors.push_back({4'b1111, 1'b1, 1'b0, 1'b0, 3'd2});
    vectors.push_back({4'b0100, 1'b1, 1'b0, 1'b0, 3'd3});
    vectors.push_back({4'b1000, 1'b0, 1'b0, 1'b0, 3'd0});
    vectors.push_back({4'b0000, 1'b0, 1'b0, 1'b0, 3'd0});

    #2;
    phase = "reset";
    pulseReset();

    phase = "table";
    for (int i = 0; i < vectors.size(); i++) begin
      v = vectors[i];
      applyStimulus(v.press, v.expLocked, v.expError, v.expLockout, v.expCount);
    end

    phase = "change";
    enterCode(8'b01_01_10_10, 1'b0, 1'b0, 1'b0, 1'b0);
    enterCode(8'b01_01_10_10, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "oldcode";
    enterCode(8'b11_10_01_00, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0, 3'd0);

    phase = "newcode";
    enterCode(8'b01_01_10_10, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "confirmbad";
    enterCode(8'b01_01_01_01, 1'b0, 1'b0, 1'b0, 1'b0);
    enterCode(8'b00_01_01_01, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0, 3'd0);
    enterCode(8'b11_11_11_11, 1'b0, 1'b0, 1'b0, 1'b0);
    enterCode(8'b11_11_11_11, 1'b0, 1'b1, 1'b0, 1'b0);
    enterCode(8'b01_01_10_10, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0, 3'd0);

    phase = "confirmtimeout";
    enterCode(8'b11_11_11_11, 1'b1, 1'b0, 1'b0, 1'b0);
    enterCode(8'b11_10_01_00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(digitPress(2'd0), 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(digitPress(2'd1), 1'b0, 1'b0, 1'b0, 3'd2);
    idle(19, 1'b0, 1'b0, 3'd2);
    idle(1, 1'b0, 1'b0, 3'd0);
    enterCode(8'b10_10_10_10, 1'b0, 1'b0, 1'b0, 1'b0);
    enterCode(8'b10_10_10_10, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "timeout";
    applyStimulus(digitPress(2'd0), 1'b1, 1'b0, 1'b0, 3'd1);
    for (int i = 1; i <= 19; i++) begin
      applyStimulus((i % 5 == 0) ? 4'b0011 : 4'b0000, 1'b1, 1'b0, 1'b0, 3'd1);
    end
    applyStimulus(digitPress(2'd1), 1'b1, 1'b0, 1'b0, 3'd2);
    idle(19, 1'b1, 1'b0, 3'd2);
    idle(1, 1'b1, 1'b0, 3'd0);
    enterCode(8'b10_10_10_10, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "lockout";
    pulseReset();
    reachLockout();
    for (int i = 1; i <= 49; i++) begin
      applyStimulus((i % 3 == 0) ? digitPress(2'(i % 4)) : 4'b0000, 1'b1, 1'b0, 1'b1, 3'd0);
    end
    idle(1, 1'b1, 1'b0, 3'd0);
    enterCode(8'b11_11_11_11, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0, 3'd0);
    enterCode(8'b11_10_01_00, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "resetmid";
    pulseReset();
    applyStimulus(digitPress(2'd0), 1'b1, 1'b0, 1'b0, 3'd1);
    applyStimulus(digitPress(2'd1), 1'b1, 1'b0, 1'b0, 3'd2);
    applyStimulus(digitPress(2'd2), 1'b1, 1'b0, 1'b0, 3'd3);
    pulseReset();
    enterCode(8'b11_10_01_00, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "resetlockout";
    pulseReset();
    reachLockout();
    idle(5, 1'b1, 1'b1, 3'd0);
    pulseReset();
    enterCode(8'b11_10_01_00, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
